// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts a captured pattern out MSB-first, one bit per clock,
// with optional repetitions separated by GAP idle cycles and a start/busy/done handshake.
module seq_pattern_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 2,
  parameter int unsigned LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic [CNT_W-1:0] reps,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LEN_W-1:0] WidthL = LEN_W'(WIDTH);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pat_q;      // captured pattern, active field left-aligned to the MSB
  logic [WIDTH-1:0] shreg_q;    // bits still to send in the current repetition
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_idx_q;  // index of the bit currently on out
  logic [CNT_W-1:0] rep_q;
  logic [GapW-1:0]  gap_cnt_q;

  logic [LEN_W-1:0] len_c;
  logic [WIDTH-1:0] pat_al;

  always_comb begin
    len_c  = (length == '0 || length > WidthL) ? WidthL : length;
    pat_al = pattern << (WidthL - len_c);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      shreg_q   <= '0;
      len_q     <= '0;
      bit_idx_q <= '0;
      rep_q     <= '0;
      gap_cnt_q <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state_q   <= StIdle;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            pat_q     <= pat_al;
            shreg_q   <= pat_al << 1;
            len_q     <= len_c;
            bit_idx_q <= len_c - 1'b1;
            rep_q     <= reps;
            out       <= pat_al[WIDTH-1];
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StSend;
          end
        end
        StSend: begin
          if (bit_idx_q != '0) begin
            bit_idx_q <= bit_idx_q - 1'b1;
            out       <= shreg_q[WIDTH-1];
            shreg_q   <= shreg_q << 1;
          end else if (rep_q != '0) begin
            rep_q <= rep_q - 1'b1;
            if (GAP > 0) begin
              gap_cnt_q <= GapW'(GAP - 1);
              out       <= 1'b0;
              out_valid <= 1'b0;
              state_q   <= StGap;
            end else begin
              // Back-to-back reload keeps the stream gapless when GAP is zero.
              bit_idx_q <= len_q - 1'b1;
              out       <= pat_q[WIDTH-1];
              shreg_q   <= pat_q << 1;
            end
          end else begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= StDone;
          end
        end
        StGap: begin
          if (gap_cnt_q == '0) begin
            bit_idx_q <= len_q - 1'b1;
            out       <= pat_q[WIDTH-1];
            shreg_q   <= pat_q << 1;
            out_valid <= 1'b1;
            state_q   <= StSend;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: one instance with GAP=2, one with GAP=0, sharing stimulus.
module tb_seq_pattern_gen;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LEN_W = $clog2(WIDTH) + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic [CNT_W-1:0] reps;

  logic out0, out_valid0, busy0, done0;
  logic out1, out_valid1, busy1, done1;
  logic [3:0] st0, st1;

  assign st0 = {out0, out_valid0, busy0, done0};
  assign st1 = {out1, out_valid1, busy1, done1};

  seq_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(2)) dut0 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .length(length), .reps(reps), .out(out0), .out_valid(out_valid0), .busy(busy0),
    .done(done0)
  );

  seq_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(0)) dut1 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .length(length), .reps(reps), .out(out1), .out_valid(out_valid1), .busy(busy1),
    .done(done1)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_tx(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l,
                          input logic [CNT_W-1:0] r);
    pattern = p;
    length  = l;
    reps    = r;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  initial begin
    logic [7:0] p;
    logic [3:0] det;
    int         busy_cnt;

    reset = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; length = '0; reps = '0;
    step();
    step();
    check("reset_dut0", st0, 4'b0000);
    check("reset_dut1", st1, 4'b0000);
    reset = 1'b0;
    step();
    check("idle_dut0", st0, 4'b0000);

    // 05, length 4, single send: 0,1,0,1 then done
    start_tx(8'h05, 4'd4, 4'd0);
    p = 8'h05;
    det = '0;
    for (int i = 3; i >= 0; i--) begin
      check($sformatf("t1_bit%0d", i), st0, {p[i], 3'b110});
      if (out_valid0) det = {det[2:0], out0};
      step();
    end
    check("t1_done", st0, 4'b0001);
    check("t1_det0101", det, 4'b0101);
    step();
    check("t1_idle", st0, 4'b0000);

    // A5, length 0 -> 8, reps 1, gap 2 on dut0
    start_tx(8'hA5, 4'd0, 4'd1);
    p = 8'hA5;
    busy_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 7; i >= 0; i--) begin
        check($sformatf("t2_r%0d_bit%0d", r, i), st0, {p[i], 3'b110});
        if (busy0) busy_cnt++;
        step();
      end
      if (r == 0) begin
        for (int g = 0; g < 2; g++) begin
          check($sformatf("t2_gap%0d", g), st0, 4'b0010);
          if (busy0) busy_cnt++;
          step();
        end
      end
    end
    check("t2_done", st0, 4'b0001);
    check("t2_busy_cycles", busy_cnt, 18);
    step();
    step();

    // length 1, bit0=1, reps 3, GAP 0 on dut1
    start_tx(8'h01, 4'd1, 4'd3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_rep%0d", i), st1, 4'b1110);
      step();
    end
    check("t3_done", st1, 4'b0001);
    step();
    check("t3_idle", st1, 4'b0000);
    for (int i = 0; i < 12; i++) step();
    check("t3_dut0_idle", st0, 4'b0000);

    // abort on 3rd bit, then restart with new inputs; length 12 clamps to 8
    start_tx(8'hC3, 4'd8, 4'd0);
    p = 8'hC3;
    for (int i = 7; i >= 5; i--) begin
      check($sformatf("t4_bit%0d", i), st0, {p[i], 3'b110});
      if (i > 5) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_abort_dut0", st0, 4'b0000);
    check("t4_abort_dut1", st1, 4'b0000);
    start_tx(8'h3C, 4'd12, 4'd0);
    p = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      check($sformatf("t4_re_bit%0d", i), st0, {p[i], 3'b110});
      step();
    end
    check("t4_done", st0, 4'b0001);
    step();
    step();

    // start held high and inputs changed throughout SEND, GAP and DONE
    start_tx(8'h96, 4'd6, 4'd1);
    p = 8'h96;
    start = 1'b1; pattern = 8'hFF; length = 4'd3; reps = 4'd0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 5; i >= 0; i--) begin
        check($sformatf("t5_r%0d_bit%0d", r, i), st0, {p[i], 3'b110});
        step();
      end
      if (r == 0) begin
        for (int g = 0; g < 2; g++) begin
          check($sformatf("t5_gap%0d", g), st0, 4'b0010);
          step();
        end
      end
    end
    check("t5_done", st0, 4'b0001);
    step();
    check("t5_idle_after_done", st0, 4'b0000);
    start = 1'b0;
    step();
    check("t5_still_idle", st0, 4'b0000);

    // reset mid-gap
    start_tx(8'hA5, 4'd4, 4'd1);
    p = 8'hA5;
    for (int i = 3; i >= 0; i--) begin
      check($sformatf("t6_bit%0d", i), st0, {p[i], 3'b110});
      step();
    end
    check("t6_gap", st0, 4'b0010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_reset", st0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t6_idle%0d", i), st0, 4'b0000);
    end
    start_tx(8'h02, 4'd2, 4'd0);
    check("t6_new_bit1", st0, 4'b1110);
    step();
    check("t6_new_bit0", st0, 4'b0110);
    step();
    check("t6_new_done", st0, 4'b0001);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
